// File: rtl/rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rf_operand_fetch
// Brief    : General-purpose register file with write-back port, debug read
//            port and ALU operand A/B selection for a single-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
module rf_operand_fetch #(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RFWr,
    input  logic [$clog2(NREG)-1:0]  WR,
    input  logic [WIDTH-1:0]         WD,
    input  logic [$clog2(NREG)-1:0]  rs,
    input  logic [$clog2(NREG)-1:0]  rt,
    input  logic [4:0]               shamt,
    input  logic [15:0]              imm16,
    input  logic                     EXTOp,
    input  logic                     ALUSrcA,
    input  logic [1:0]               ALUSrcB,
    output logic [WIDTH-1:0]         A,
    output logic [WIDTH-1:0]         B,
    output logic [WIDTH-1:0]         RD2,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int AW = $clog2(NREG);

    localparam logic [1:0] c_SRCB_RD2 = 2'b00;
    localparam logic [1:0] c_SRCB_EXT = 2'b01;
    localparam logic [1:0] c_SRCB_LUI = 2'b10;

    // Register 0 is hard-wired to zero; the others come from per-register flops.
    logic [WIDTH-1:0] rf_w [NREG];
    logic             wr_en_w;
    logic [WIDTH-1:0] rd1_w;
    logic [WIDTH-1:0] rd2_w;
    logic [WIDTH-1:0] ext_w;

    // Writes to $0 are dropped here so no storage for $0 is ever needed.
    assign wr_en_w  = RFWr && (WR != '0);
    assign rf_w[0]  = '0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_reg
            logic [WIDTH-1:0] reg_q;
            logic [WIDTH-1:0] reg_d;

            // Next value: load WD when this register is the write target.
            always_comb begin
                reg_d = reg_q;
                if (wr_en_w && (WR == AW'(i))) begin
                    reg_d = WD;
                end
            end

            // Register storage; reset clears it immediately and blocks writes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign rf_w[i] = reg_q;
        end
    endgenerate

    // Read ports: optional write-through forwarding of the in-flight write.
    // The forwarding condition is gated by RFWr so an unknown WD cannot leak
    // onto the read data while no write is requested.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign rd1_w = (wr_en_w && (WR == rs)) ? WD : rf_w[rs];
            assign rd2_w = (wr_en_w && (WR == rt)) ? WD : rf_w[rt];
        end else begin : g_no_bypass
            assign rd1_w = rf_w[rs];
            assign rd2_w = rf_w[rt];
        end
    endgenerate

    // The debug port always shows the stored value, never the forwarded one.
    assign dbg_data = rf_w[dbg_addr];
    assign RD2      = rd2_w;

    // Immediate extension: sign or zero fill of the upper bits.
    assign ext_w = EXTOp ? {{(WIDTH-16){imm16[15]}}, imm16}
                         : {{(WIDTH-16){1'b0}}, imm16};

    // Operand A: register value, or the shift amount for shift instructions.
    assign A = ALUSrcA ? {{(WIDTH-5){1'b0}}, shamt} : rd1_w;

    // Operand B: register, extended immediate, LUI-shifted immediate or zero.
    always_comb begin
        B = '0;
        case (ALUSrcB)
            c_SRCB_RD2: B = rd2_w;
            c_SRCB_EXT: B = ext_w;
            c_SRCB_LUI: B = {imm16, {(WIDTH-16){1'b0}}};
            default:    B = '0;
        endcase
    end

endmodule
`default_nettype wire
